mod10_seq_checker: RTL and testbench
====================================

// Module: mod10_seq_checker
// PURPOSE
//  Receive-side monitor for the 4-bit mod-10 count bus produced by the mod10 counter.
//  Locks onto the incoming count stream and tracks the next expected value.
//  Flags and counts out-of-range values and sequence breaks, and counts wraps (9->0).
//  Sits beside the counter in the datapath or bench as a self-checking consumer.
// PARAMETERS
//  MODULUS      10  count period; legal values 0..MODULUS-1; requires 2 <= MODULUS <= 2**WIDTH
//  WIDTH        4   count bus width
//  LOCK_CYCLES  3   consecutive in-sequence samples needed to assert locked; must be >= 1
//  CNT_W        8   width of err_count and wrap_count
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      synchronous reset, active-high
//  in_vld      in   1      count is sampled only when 1
//  count       in   WIDTH  observed counter value
//  locked      out  1      stream is tracked and in sequence
//  expected    out  WIDTH  next expected value; valid while locked
//  err_pulse   out  1      one-cycle pulse, registered one cycle after the offending sample
//  err_count   out  CNT_W  saturating error count
//  wrap_count  out  CNT_W  wrapping count of locked MODULUS-1 -> 0 transitions
// BEHAVIOUR
//  - Reset: state SEEK, match_cnt=0, expected=0; all outputs 0 on the clock after rst=1.
//    rst overrides in_vld and clears both counters.
//  - next(x) = (x == MODULUS-1) ? 0 : x+1.
//  - in_vld=0: all state held; err_pulse=0.
//  - Range error, any state (count >= MODULUS with in_vld=1):
//    err_pulse=1, err_count+1 (saturating), state -> SEEK, locked=0.
//  - SEEK, legal sample: expected=next(count), match_cnt=1.
//    Go to LOCKED if LOCK_CYCLES==1, else LOCKING.
//  - LOCKING, sample == expected: match_cnt+1, expected=next.
//    On match_cnt reaching LOCK_CYCLES, go to LOCKED.
//  - LOCKING, legal sample != expected: reseed as in SEEK. No error flagged.
//  - LOCKED, sample == expected: expected=next; wrap_count+1 when count == MODULUS-1.
//  - LOCKED, legal sample != expected: err_pulse=1, err_count+1, locked=0.
//    Reseed as in SEEK (state LOCKING, match_cnt=1).
//  - locked is registered: it rises on the clock that completes the LOCK_CYCLES-th match,
//    i.e. visible the cycle after that sample.
//  - err_count saturates at all-ones. wrap_count wraps modulo 2**CNT_W.
//  - Back-to-back errors: err_pulse stays high for consecutive offending samples.
// CONFIGURATION
//  MOD10_CHK_STICKY_EN defined:
//    - adds ports err_sticky (out, 1) and err_clr (in, 1).
//    - err_sticky sets on any err_pulse condition and holds until err_clr=1 or rst.
//    - set wins over err_clr in the same cycle.
//  MOD10_CHK_STICKY_EN undefined: neither port exists; all other behaviour identical.
// STRUCTURE
//  - Package mod10_chk_pkg: state enum typedef {SEEK, LOCKING, LOCKED}, default
//    MODULUS/WIDTH constants, function next_val().
//  - Sub-module sat_counter (parameter CNT_W, SAT 0/1): used for err_count (SAT=1)
//    and wrap_count (SAT=0).
//  - Everything else is one always block for the FSM and registers.
// TESTING
//  1 Reset, then stream 0,1,2,...,9,0,1 with in_vld=1 -> locked=1 from the cycle after
//    sample '2'; wrap_count=1 after 9->0; err_count=0.
//  2 Locked; drive 5 where 4 is expected, then 6,7 -> err_pulse high exactly 1 cycle,
//    err_count=1, locked=0, locked=1 again after sample 7.
//  3 Locked; drive count=12 -> err_pulse=1, err_count+1, state SEEK.
//    Next samples 3,4,5 -> relock.
//  4 Locked; samples 3, in_vld=0 for 4 cycles with count=0, then 4 -> no error, locked stays 1.
//  5 CNT_W=2, force 5 mismatches -> err_count stays 3; 5 wraps -> wrap_count=1.
//  6 rst=1 for one cycle while locked -> next cycle locked=0, err_count=0, wrap_count=0,
//    expected=0.
//    With MOD10_CHK_STICKY_EN: err_sticky holds after an error until err_clr.

Source files
------------

// File: rtl/mod10_seq_checker_pkg.sv
// Shared types and helpers for the mod-10 count stream checker.
// Optional sticky error flag is enabled by defining MOD10_CHK_STICKY_EN.
package mod10_chk_pkg;

  typedef enum logic [1:0] {
    SEEK    = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam int MOD10_MODULUS = 10;
  localparam int MOD10_WIDTH   = 4;

  // Successor of x in a counter of period modulus.
  function automatic int next_val(input int x, input int modulus);
    return (x == modulus - 1) ? 0 : x + 1;
  endfunction

endpackage

// File: rtl/mod10_seq_checker_sat_counter.sv
// Event counter that either saturates at all-ones (SAT=1) or wraps (SAT=0).
module sat_counter #(
  parameter int CNT_W = 8,
  parameter int SAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;
  logic             w_hold;

  assign w_hold  = (SAT != 0) && (&r_count);
  assign o_count = r_count;

  // Count one per i_inc; a saturating counter stops at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && !w_hold) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/mod10_seq_checker.sv
// Receive-side monitor for a mod-MODULUS count bus: locks onto the stream,
// tracks the next expected value, counts errors (saturating) and wraps.
// Define MOD10_CHK_STICKY_EN to add the err_sticky / err_clr ports.
//
// Handshake: in_vld qualifies count for one cycle; there is no backpressure,
// every cycle with in_vld=1 is one sample and cycles with in_vld=0 hold state.
module mod10_seq_checker
  import mod10_chk_pkg::*;
#(
  parameter int MODULUS     = MOD10_MODULUS,
  parameter int WIDTH       = MOD10_WIDTH,
  parameter int LOCK_CYCLES = 3,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] count,
  output logic             locked,
  output logic [WIDTH-1:0] expected,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count,
  output state_e           dbg_state
`ifdef MOD10_CHK_STICKY_EN
  ,
  output logic             err_sticky,
  input  logic             err_clr
`endif
);

  localparam int MW = $clog2(LOCK_CYCLES + 1);

  state_e           r_state, n_state;
  logic [MW-1:0]    r_match_cnt, n_match_cnt;
  logic [WIDTH-1:0] r_expected, n_expected;
  logic             r_locked, n_locked;
  logic             r_err_pulse, n_err_pulse;

  logic             w_legal, w_match, w_at_top, w_match_full;
  logic [WIDTH-1:0] w_next_cnt;
  state_e           w_seed_state;
  logic             w_seed_locked;
  logic             w_err_inc, w_wrap_inc;

  assign w_legal       = int'(count) < MODULUS;
  assign w_match       = (count == r_expected);
  assign w_at_top      = int'(count) == MODULUS - 1;
  assign w_next_cnt    = WIDTH'(next_val(int'(count), MODULUS));
  assign w_match_full  = (int'(r_match_cnt) + 1) >= LOCK_CYCLES;
  // A fresh seed already counts as one match, so a one-sample lock is immediate.
  assign w_seed_state  = (LOCK_CYCLES == 1) ? LOCKED : LOCKING;
  assign w_seed_locked = (LOCK_CYCLES == 1);

  // Next-state, tracking and error/wrap event decode.
  always_comb begin
    n_state     = r_state;
    n_match_cnt = r_match_cnt;
    n_expected  = r_expected;
    n_locked    = r_locked;
    n_err_pulse = 1'b0;
    w_err_inc   = 1'b0;
    w_wrap_inc  = 1'b0;
    if (in_vld) begin
      if (!w_legal) begin
        n_err_pulse = 1'b1;
        w_err_inc   = 1'b1;
        n_state     = SEEK;
        n_locked    = 1'b0;
        n_match_cnt = '0;
      end else begin
        unique case (r_state)
          LOCKING: begin
            if (w_match) begin
              n_match_cnt = r_match_cnt + MW'(1);
              n_expected  = w_next_cnt;
              if (w_match_full) begin
                n_state  = LOCKED;
                n_locked = 1'b1;
              end
            end else begin
              n_state     = w_seed_state;
              n_match_cnt = MW'(1);
              n_expected  = w_next_cnt;
              n_locked    = w_seed_locked;
            end
          end
          LOCKED: begin
            if (w_match) begin
              n_expected = w_next_cnt;
              w_wrap_inc = w_at_top;
            end else begin
              n_err_pulse = 1'b1;
              w_err_inc   = 1'b1;
              n_state     = w_seed_state;
              n_match_cnt = MW'(1);
              n_expected  = w_next_cnt;
              n_locked    = w_seed_locked;
            end
          end
          default: begin
            n_state     = w_seed_state;
            n_match_cnt = MW'(1);
            n_expected  = w_next_cnt;
            n_locked    = w_seed_locked;
          end
        endcase
      end
    end
  end

  // State and tracking registers; rst overrides in_vld.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= SEEK;
      r_match_cnt <= '0;
      r_expected  <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_state     <= n_state;
      r_match_cnt <= n_match_cnt;
      r_expected  <= n_expected;
      r_locked    <= n_locked;
      r_err_pulse <= n_err_pulse;
    end
  end

  sat_counter #(.CNT_W(CNT_W), .SAT(1)) u_err_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_err_inc),
    .o_count (err_count)
  );

  sat_counter #(.CNT_W(CNT_W), .SAT(0)) u_wrap_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_wrap_inc),
    .o_count (wrap_count)
  );

  assign locked    = r_locked;
  assign expected  = r_expected;
  assign err_pulse = r_err_pulse;
  assign dbg_state = r_state;

`ifdef MOD10_CHK_STICKY_EN
  logic r_err_sticky;

  // Sticky error flag: a new error wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_sticky <= 1'b0;
    end else if (n_err_pulse) begin
      r_err_sticky <= 1'b1;
    end else if (err_clr) begin
      r_err_sticky <= 1'b0;
    end
  end

  assign err_sticky = r_err_sticky;
`endif

endmodule

// File: tb/tb_mod10_seq_checker.sv
// Bench for mod10_seq_checker: default instance (CNT_W=8) plus a CNT_W=2
// instance sharing the same input stream. Define MOD10_CHK_STICKY_EN to
// exercise the sticky flag.
module tb_mod10_seq_checker;
  import mod10_chk_pkg::*;

  localparam int W = 29;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_vld;
  logic [3:0] count;
  logic       err_clr;

  logic       locked, err_pulse, locked2, err_pulse2;
  logic [3:0] expected, expected2;
  logic [7:0] err_count, wrap_count;
  logic [1:0] err_count2, wrap_count2;
  state_e     dbg_state, dbg_state2;
  logic       sticky_obs;

`ifdef MOD10_CHK_STICKY_EN
  logic err_sticky, err_sticky2;
  assign sticky_obs = err_sticky;
`else
  assign sticky_obs = 1'b0;
`endif

  mod10_seq_checker dut (
    .clk        (clk),
    .rst        (rst),
    .in_vld     (in_vld),
    .count      (count),
    .locked     (locked),
    .expected   (expected),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .wrap_count (wrap_count),
    .dbg_state  (dbg_state)
`ifdef MOD10_CHK_STICKY_EN
    ,
    .err_sticky (err_sticky),
    .err_clr    (err_clr)
`endif
  );

  mod10_seq_checker #(.CNT_W(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .in_vld     (in_vld),
    .count      (count),
    .locked     (locked2),
    .expected   (expected2),
    .err_pulse  (err_pulse2),
    .err_count  (err_count2),
    .wrap_count (wrap_count2),
    .dbg_state  (dbg_state2)
`ifdef MOD10_CHK_STICKY_EN
    ,
    .err_sticky (err_sticky2),
    .err_clr    (err_clr)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state (0=SEEK, 1=LOCKING, 2=LOCKED), LOCK_CYCLES=3.
  int m_state, m_match, m_exp, m_locked, m_pulse, m_err, m_wrap, m_sticky;

  function automatic int nx(input int x);
    return (x == 9) ? 0 : x + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_seed(input int c);
    m_exp   = nx(c);
    m_match = 1;
    m_state = 1;
  endtask

  task automatic model_step(input logic r, input logic v, input int c, input logic clr);
    if (r) begin
      m_state = 0; m_match = 0; m_exp = 0; m_locked = 0;
      m_pulse = 0; m_err = 0; m_wrap = 0; m_sticky = 0;
    end else begin
      m_pulse = 0;
      if (v) begin
        if (c >= 10) begin
          m_pulse = 1; m_err++; m_state = 0; m_locked = 0; m_match = 0;
        end else if (m_state == 0) begin
          model_seed(c);
        end else if (m_state == 1) begin
          if (c == m_exp) begin
            m_match++;
            m_exp = nx(c);
            if (m_match == 3) begin
              m_state  = 2;
              m_locked = 1;
            end
          end else begin
            model_seed(c);
          end
        end else begin
          if (c == m_exp) begin
            if (c == 9) m_wrap++;
            m_exp = nx(c);
          end else begin
            m_pulse = 1; m_err++; m_locked = 0;
            model_seed(c);
          end
        end
      end
      if (m_pulse == 1) m_sticky = 1;
      else if (clr) m_sticky = 0;
    end
  endtask

  function automatic logic [W-1:0] model_pack();
    logic [7:0] e8, w8;
    logic [1:0] e2, w2, st;
    e8 = 8'((m_err > 255) ? 255 : m_err);
    w8 = 8'(m_wrap % 256);
    e2 = 2'((m_err > 3) ? 3 : m_err);
    w2 = 2'(m_wrap % 4);
    st = 2'(m_state);
    return {m_sticky[0], st, m_locked[0], m_pulse[0], e8, w8, e2, w2, 4'(m_exp)};
  endfunction

  task automatic check_outputs(input logic [W-1:0] e);
`ifdef MOD10_CHK_STICKY_EN
    chk("sb_sticky", 32'(sticky_obs), 32'(e[28]));
`endif
    chk("sb_state",      32'(dbg_state),   32'(e[27:26]));
    chk("sb_locked",     32'(locked),      32'(e[25]));
    chk("sb_err_pulse",  32'(err_pulse),   32'(e[24]));
    chk("sb_err_count",  32'(err_count),   32'(e[23:16]));
    chk("sb_wrap_count", 32'(wrap_count),  32'(e[15:8]));
    chk("sb_err_count2", 32'(err_count2),  32'(e[7:6]));
    chk("sb_wrap_count2",32'(wrap_count2), 32'(e[5:4]));
    chk("sb_expected",   32'(expected),    32'(e[3:0]));
    chk("sb_locked2",    32'(locked2),     32'(e[25]));
    chk("sb_expected2",  32'(expected2),   32'(e[3:0]));
  endtask

  // ---------------- driver ----------------
  // Check the outputs of the previous sample, then drive the next one.
  task automatic step(input logic r, input logic v, input int c, input logic clr);
    @(negedge clk);
    if (exp_q.size() > 0) check_outputs(exp_q.pop_front());
    rst     = r;
    in_vld  = v;
    count   = 4'(c);
    err_clr = clr;
    model_step(r, v, c, clr);
    exp_q.push_back(model_pack());
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int v;
    int bad;
    int nw;
    rst = 1'b1; in_vld = 1'b0; count = '0; err_clr = 1'b0;

    // Reset
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // 1: stream 0..9,0,1 -> lock after sample 2, one wrap
    for (int i = 0; i < 12; i++) step(0, 1, i % 10, 0);
    step(0, 0, 0, 0);
    chk("t1_locked",   32'(locked),     32'd1);
    chk("t1_err",      32'(err_count),  32'd0);
    chk("t1_wrap",     32'(wrap_count), 32'd1);
    chk("t1_expected", 32'(expected),   32'd2);

    // 2: sequence break (5 where 4 expected), relock on 6,7
    step(0, 1, 2, 0);
    step(0, 1, 3, 0);
    step(0, 1, 5, 0);
    step(0, 1, 6, 0);
    chk("t2_pulse",  32'(err_pulse), 32'd1);
    chk("t2_unlock", 32'(locked),    32'd0);
    step(0, 1, 7, 0);
    chk("t2_pulse_one", 32'(err_pulse), 32'd0);
    step(0, 0, 0, 0);
    chk("t2_err",    32'(err_count), 32'd1);
    chk("t2_relock", 32'(locked),    32'd1);

    // 3: out-of-range value forces SEEK, relock on 3,4,5
    step(0, 1, 12, 0);
    step(0, 1, 3, 0);
    chk("t3_seek",  32'(dbg_state), 32'(SEEK));
    chk("t3_pulse", 32'(err_pulse), 32'd1);
    step(0, 1, 4, 0);
    step(0, 1, 5, 0);
    step(0, 0, 0, 0);
    chk("t3_relock", 32'(locked),    32'd1);
    chk("t3_err",    32'(err_count), 32'd2);

    // 4: in_vld gaps hold state
    step(0, 1, 6, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(0, 1, 7, 0);
    step(0, 0, 0, 0);
    chk("t4_locked", 32'(locked),    32'd1);
    chk("t4_err",    32'(err_count), 32'd2);

    // 6: one-cycle reset while locked (in_vld=1 is overridden)
    step(1, 1, 8, 0);
    step(0, 0, 0, 0);
    chk("t6_locked",   32'(locked),     32'd0);
    chk("t6_err",      32'(err_count),  32'd0);
    chk("t6_wrap",     32'(wrap_count), 32'd0);
    chk("t6_expected", 32'(expected),   32'd0);

    // 5: five locked mismatches, then five wraps
    for (int i = 0; i < 4; i++) step(0, 1, i, 0);
    v = 4;
    for (int k = 0; k < 5; k++) begin
      bad = (v + 5 + int'($urandom_range(0, 3))) % 10;
      step(0, 1, bad, 0);
      v = nx(bad);
      step(0, 1, v, 0);
      v = nx(v);
      step(0, 1, v, 0);
      v = nx(v);
    end
    nw = 0;
    while (nw < 5) begin
      step(0, 1, v, 0);
      if (v == 9) nw++;
      v = nx(v);
    end
    step(0, 0, 0, 0);
    chk("t5_err_sat2", 32'(err_count2),  32'd3);
    chk("t5_err8",     32'(err_count),   32'd5);
    chk("t5_wrap2",    32'(wrap_count2), 32'd1);
    chk("t5_wrap8",    32'(wrap_count),  32'd5);

`ifdef MOD10_CHK_STICKY_EN
    // Sticky flag holds until cleared; a new error wins over clear
    chk("st_hold", 32'(sticky_obs), 32'd1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("st_clr", 32'(sticky_obs), 32'd0);
    step(0, 1, 15, 1);
    step(0, 0, 0, 0);
    chk("st_set_wins", 32'(sticky_obs), 32'd1);
`endif

    // Drain the scoreboard
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("sb_drained", 32'(exp_q.size()), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
